uart_tx_core: RTL and testbench



---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_baud_tick.sv | 50 +++++
 rtl/uart_tx_core.sv | 171 +++++++++++++++++
 tb/tb_uart_tx_core.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmitter and receiver: state and parity encodings
// plus the baud divisor helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } txState_e;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_ODD,
    PAR_EVEN
  } parity_e;

  function automatic int unsigned clks_per_bit(input int unsigned sysFreq,
                                               input int unsigned baudRate);
    return sysFreq / baudRate;
  endfunction

  // Odd wins when both checks are requested.
  function automatic parity_e parityMode(input logic checkOdd, input logic checkEven);
    if (checkOdd) return PAR_ODD;
    if (checkEven) return PAR_EVEN;
    return PAR_NONE;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period down-counter: reloads on clear and at every bit boundary, and flags the
// last cycle of a bit (bitEnd) and the cycle before it (bitPreEnd), both registered.
module uart_baud_tick #(
  parameter int unsigned CPB = 33
) (
  input  logic Clk,
  input  logic Rst,
  input  logic iClear,
  input  logic iRun,
  output logic oBitEnd,
  output logic oBitPreEnd
);

  localparam int unsigned CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CPB - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cntNext;
  logic             active;
  logic             bitEnd;
  logic             bitPreEnd;

  assign active = iClear | iRun;

  always_comb begin
    cntNext = '0;
    if (iClear) begin
      cntNext = RELOAD;
    end else if (iRun) begin
      cntNext = (cnt == '0) ? RELOAD : cnt - CNT_W'(1);
    end
  end

  // Flags are computed from the next count so they line up with the cycle they describe.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt       <= '0;
      bitEnd    <= 1'b0;
      bitPreEnd <= 1'b0;
    end else begin
      cnt       <= cntNext;
      bitEnd    <= active && (cntNext == '0);
      bitPreEnd <= active && (cntNext == CNT_W'(1));
    end
  end

  assign oBitEnd    = bitEnd;
  assign oBitPreEnd = bitPreEnd;

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: one byte per Val/Rdy handshake, start bit, LSB-first data,
// optional parity and STOP_BITS stop bits, with a done pulse on the last stop cycle.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_RATE = 3_000_000,
  parameter int unsigned SYS_FREQ  = 100_000_000,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 iTx_Val,
  input  logic [DATA_BITS-1:0] iTx_Data,
  input  logic                 iTx_Check_odd,
  input  logic                 iTx_Check_even,
  output logic                 oTx_Bit,
  output logic                 oTx_Rdy,
  output logic                 oTx_done
);

  localparam int unsigned CPB    = clks_per_bit(SYS_FREQ, BAUD_RATE);
  localparam int unsigned IDX_W  = $clog2(DATA_BITS + 1);
  localparam int unsigned STOP_W = 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DATA_BITS - 1);
  localparam logic [STOP_W-1:0] LAST_STOP = STOP_W'(STOP_BITS - 1);

  if (CPB < 2) begin : gBadCpb
    $error("uart_tx_core: SYS_FREQ/BAUD_RATE must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : gBadDataBits
    $error("uart_tx_core: DATA_BITS must be 5..8");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : gBadStopBits
    $error("uart_tx_core: STOP_BITS must be 1 or 2");
  end

  txState_e             state, stateNext;
  logic [DATA_BITS-1:0] dataSh, dataNext;
  parity_e              parMode, parModeNext;
  logic                 parBit, parBitNext;
  logic [IDX_W-1:0]     bitIdx, idxNext;
  logic [STOP_W-1:0]    stopIdx, stopNext;
  logic                 txBit, bitNext;
  logic                 txRdy, rdyNext;
  logic                 txDone, doneNext;
  logic                 accept;
  logic                 bitEnd;
  logic                 bitPreEnd;

  uart_baud_tick #(
    .CPB(CPB)
  ) uBaudTick (
    .Clk       (Clk),
    .Rst       (Rst),
    .iClear    (accept),
    .iRun      (state != IDLE),
    .oBitEnd   (bitEnd),
    .oBitPreEnd(bitPreEnd)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= IDLE;
      dataSh  <= '0;
      parMode <= PAR_NONE;
      parBit  <= 1'b0;
      bitIdx  <= '0;
      stopIdx <= '0;
      txBit   <= 1'b1;
      txRdy   <= 1'b1;
      txDone  <= 1'b0;
    end else begin
      state   <= stateNext;
      dataSh  <= dataNext;
      parMode <= parModeNext;
      parBit  <= parBitNext;
      bitIdx  <= idxNext;
      stopIdx <= stopNext;
      txBit   <= bitNext;
      txRdy   <= rdyNext;
      txDone  <= doneNext;
    end
  end

  // Each transition loads the line value for the upcoming bit so oTx_Bit stays registered.
  always_comb begin
    stateNext   = state;
    dataNext    = dataSh;
    parModeNext = parMode;
    parBitNext  = parBit;
    idxNext     = bitIdx;
    stopNext    = stopIdx;
    bitNext     = txBit;
    rdyNext     = txRdy;
    doneNext    = 1'b0;
    accept      = 1'b0;

    unique case (state)
      IDLE: begin
        bitNext = 1'b1;
        rdyNext = 1'b1;
        if (iTx_Val) begin
          accept      = 1'b1;
          stateNext   = START;
          dataNext    = iTx_Data;
          parModeNext = parityMode(iTx_Check_odd, iTx_Check_even);
          parBitNext  = iTx_Check_odd ? ~^iTx_Data : ^iTx_Data;
          bitNext     = 1'b0;
          rdyNext     = 1'b0;
        end
      end
      START: begin
        if (bitEnd) begin
          stateNext = DATA;
          bitNext   = dataSh[0];
          dataNext  = dataSh >> 1;
          idxNext   = '0;
        end
      end
      DATA: begin
        if (bitEnd) begin
          if (bitIdx == LAST_IDX) begin
            if (parMode != PAR_NONE) begin
              stateNext = PARITY;
              bitNext   = parBit;
            end else begin
              stateNext = STOP;
              bitNext   = 1'b1;
              stopNext  = '0;
            end
          end else begin
            idxNext  = bitIdx + IDX_W'(1);
            bitNext  = dataSh[0];
            dataNext = dataSh >> 1;
          end
        end
      end
      PARITY: begin
        if (bitEnd) begin
          stateNext = STOP;
          bitNext   = 1'b1;
          stopNext  = '0;
        end
      end
      STOP: begin
        if (bitPreEnd && stopIdx == LAST_STOP) begin
          doneNext = 1'b1;
        end
        if (bitEnd) begin
          if (stopIdx == LAST_STOP) begin
            stateNext = IDLE;
            rdyNext   = 1'b1;
          end else begin
            stopNext = stopIdx + STOP_W'(1);
          end
        end
      end
      default: begin
        stateNext = IDLE;
        bitNext   = 1'b1;
        rdyNext   = 1'b1;
      end
    endcase
  end

  assign oTx_Bit  = txBit;
  assign oTx_Rdy  = txRdy;
  assign oTx_done = txDone;

endmodule

// File: tb/tb_uart_tx_core.sv
// Self-checking bench for uart_tx_core at default parameters: vector table, hand-written
// corner sequences, and a random stream decoded by a behavioural line receiver.
module tb_uart_tx_core;

  localparam int CPB = 33;
  localparam int DB  = 8;
  localparam int SB  = 1;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       iTx_Val = 1'b0;
  logic [7:0] iTx_Data = 8'h00;
  logic       iTx_Check_odd = 1'b0;
  logic       iTx_Check_even = 1'b0;
  logic       oTx_Bit;
  logic       oTx_Rdy;
  logic       oTx_done;

  uart_tx_core dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .iTx_Val       (iTx_Val),
    .iTx_Data      (iTx_Data),
    .iTx_Check_odd (iTx_Check_odd),
    .iTx_Check_even(iTx_Check_even),
    .oTx_Bit       (oTx_Bit),
    .oTx_Rdy       (oTx_Rdy),
    .oTx_done      (oTx_done)
  );

  always #5 Clk = ~Clk;

  int nTests = 0;
  int nFail  = 0;

  bit         slotQ[$];
  logic [7:0] sentQ[$];
  logic [7:0] rxQ[$];
  bit         errQ[$];
  bit         monOn = 1'b0;
  bit         monPrev = 1'b1;

  typedef struct {
    logic [7:0] d;
    bit         po;
    bit         pe;
    int         expDone;
    int         expPar;
  } vec_t;

  function automatic void check(input string name, input logic signed [31:0] act,
                                input logic signed [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Frame as a list of bit slots, straight from the frame format.
  function automatic void buildSlots(input logic [7:0] d, input bit po, input bit pe);
    int ones;
    slotQ = {};
    slotQ.push_back(1'b0);
    for (int i = 0; i < DB; i++) slotQ.push_back(d[i]);
    ones = $countones(d);
    if (po) slotQ.push_back((ones % 2) == 0);
    else if (pe) slotQ.push_back((ones % 2) == 1);
    for (int i = 0; i < SB; i++) slotQ.push_back(1'b1);
  endfunction

  task automatic waitRdy(input string tag);
    int w;
    w = 0;
    while (oTx_Rdy !== 1'b1 && w < 2000) begin
      step();
      w++;
    end
    check({tag, "_rdy_before_accept"}, oTx_Rdy, 1);
  endtask

  // Send one frame from the current cycle and compare every cycle of it with the model.
  task automatic doFrame(input string tag, input logic [7:0] d, input bit po, input bit pe,
                         input bit noise, output int doneAt, output int rdyAt,
                         output int parSample);
    int len, badOff;
    logic [2:0] act, exp, badAct, badExp;
    buildSlots(d, po, pe);
    len = slotQ.size() * CPB;
    waitRdy(tag);
    iTx_Val = 1'b1; iTx_Data = d; iTx_Check_odd = po; iTx_Check_even = pe;
    doneAt = -1; rdyAt = -1; parSample = -1; badOff = -1;
    badAct = '0; badExp = '0;
    for (int off = 1; off <= len + 1; off++) begin
      step();
      if (noise && off <= len) begin
        iTx_Val = 1'($urandom_range(0, 1));
        iTx_Data = 8'($urandom);
        iTx_Check_odd = 1'($urandom);
        iTx_Check_even = 1'($urandom);
      end else begin
        iTx_Val = 1'b0;
      end
      exp = {(off <= len) ? slotQ[(off - 1) / CPB] : 1'b1, off == len + 1, off == len};
      act = {oTx_Bit, oTx_Rdy, oTx_done};
      if (act !== exp && badOff < 0) begin
        badOff = off; badAct = act; badExp = exp;
      end
      if (oTx_done === 1'b1 && doneAt < 0) doneAt = off;
      if (oTx_Rdy === 1'b1 && rdyAt < 0) rdyAt = off;
      if ((po || pe) && (off - 1) / CPB == DB + 1 && (off - 1) % CPB == CPB / 2)
        parSample = int'(oTx_Bit);
    end
    nTests++;
    if (badOff >= 0) begin
      nFail++;
      $display("FAIL %s_trace: at accept+%0d {bit,rdy,done}=%b, expected %b",
               tag, badOff, badAct, badExp);
    end
  endtask

  // Behavioural receiver: mid-bit sampling, even parity, one stop bit.
  initial begin
    forever begin
      step();
      if (monOn && monPrev == 1'b1 && oTx_Bit == 1'b0) begin : rxFrame
        logic [7:0] d;
        bit err;
        bit p;
        err = 1'b0;
        d = '0;
        repeat (CPB / 2) step();
        if (oTx_Bit !== 1'b0) err = 1'b1;
        for (int i = 0; i < DB; i++) begin
          repeat (CPB) step();
          d[i] = oTx_Bit;
        end
        repeat (CPB) step();
        p = oTx_Bit;
        if (($countones(d) + int'(p)) % 2 != 0) err = 1'b1;
        repeat (CPB) step();
        if (oTx_Bit !== 1'b1) err = 1'b1;
        rxQ.push_back(d);
        errQ.push_back(err);
        monPrev = oTx_Bit;
      end else begin
        monPrev = oTx_Bit;
      end
    end
  end

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int doneAt, rdyAt, parS, badOff, fall, errCnt, w, nRx;
    bit lineArr[0:700];
    bit rdyArr[0:700];
    bit doneSeen;
    logic [7:0] d;

    vecs[0] = '{8'hA5, 1'b0, 1'b0, 330, -1};
    vecs[1] = '{8'h07, 1'b1, 1'b0, 363, 0};
    vecs[2] = '{8'h07, 1'b0, 1'b1, 363, 1};
    vecs[3] = '{8'h07, 1'b1, 1'b1, 363, 0};
    vecs[4] = '{8'h3C, 1'b0, 1'b0, 330, -1};
    vecs[5] = '{8'hFF, 1'b0, 1'b1, 363, 0};
    vecs[6] = '{8'h00, 1'b1, 1'b0, 363, 1};
    vecs[7] = '{8'h81, 1'b0, 1'b0, 330, -1};

    // Reset held with Val high: line idle, ready, no done, nothing accepted.
    Rst = 1'b1; iTx_Val = 1'b1; iTx_Data = 8'h5A;
    for (int c = 0; c < 4; c++) begin
      step();
      check($sformatf("reset%0d_bit", c), oTx_Bit, 1);
      check($sformatf("reset%0d_rdy", c), oTx_Rdy, 1);
      check($sformatf("reset%0d_done", c), oTx_done, 0);
    end
    Rst = 1'b0; iTx_Val = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("post_reset%0d_bit", c), oTx_Bit, 1);
    end

    // Vector table.
    for (int i = 0; i < 8; i++) begin
      doFrame($sformatf("vec%0d", i), vecs[i].d, vecs[i].po, vecs[i].pe, bit'(i % 2),
              doneAt, rdyAt, parS);
      check($sformatf("vec%0d_done_at", i), doneAt, vecs[i].expDone);
      check($sformatf("vec%0d_rdy_at", i), rdyAt, vecs[i].expDone + 1);
      check($sformatf("vec%0d_parity", i), parS, vecs[i].expPar);
      repeat ($urandom_range(0, 3)) step();
    end

    // Back-to-back with Val held high; data changed while busy.
    waitRdy("b2b");
    iTx_Val = 1'b1; iTx_Data = 8'h55; iTx_Check_odd = 1'b0; iTx_Check_even = 1'b0;
    for (int off = 1; off <= 662; off++) begin
      step();
      lineArr[off] = oTx_Bit;
      rdyArr[off] = oTx_Rdy;
      iTx_Data = 8'hAA;
      iTx_Val = (off <= 331);
    end
    buildSlots(8'h55, 1'b0, 1'b0);
    badOff = -1;
    for (int off = 1; off <= 331; off++)
      if (badOff < 0 && lineArr[off] != ((off <= 330) ? slotQ[(off - 1) / CPB] : 1'b1))
        badOff = off;
    buildSlots(8'hAA, 1'b0, 1'b0);
    for (int off = 332; off <= 662; off++)
      if (badOff < 0 && lineArr[off] != ((off <= 661) ? slotQ[(off - 332) / CPB] : 1'b1))
        badOff = off;
    check("b2b_trace_first_bad_offset", badOff, -1);
    fall = -1;
    for (int off = 331; off <= 662; off++)
      if (fall < 0 && lineArr[off] == 1'b0) fall = off;
    check("b2b_second_start_at", fall, 332);
    check("b2b_rdy_at_331", int'(rdyArr[331]), 1);
    check("b2b_rdy_at_332", int'(rdyArr[332]), 0);

    // Reset mid-DATA: immediate idle, no done, then a clean frame.
    waitRdy("abort");
    iTx_Val = 1'b1; iTx_Data = 8'h3C;
    doneSeen = 1'b0;
    for (int off = 1; off <= 100; off++) begin
      step();
      iTx_Val = 1'b0;
      if (oTx_done === 1'b1) doneSeen = 1'b1;
    end
    check("abort_line_before_reset", oTx_Bit, 1);
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    check("abort_bit", oTx_Bit, 1);
    check("abort_rdy", oTx_Rdy, 1);
    check("abort_done", oTx_done, 0);
    for (int c = 0; c < 4; c++) begin
      step();
      if (oTx_done === 1'b1 || oTx_Bit !== 1'b1) doneSeen = 1'b1;
    end
    check("abort_no_done_or_low", int'(doneSeen), 0);
    doFrame("abort_resend", 8'h3C, 1'b0, 1'b0, 1'b0, doneAt, rdyAt, parS);
    check("abort_resend_done_at", doneAt, 330);

    // Random stream, even parity, decoded by the behavioural receiver.
    step();
    monPrev = 1'b1;
    monOn = 1'b1;
    for (int n = 0; n < 96; n++) begin
      d = 8'($urandom);
      w = 0;
      while (oTx_Rdy !== 1'b1 && w < 1000) begin
        step();
        w++;
      end
      if (w >= 1000) check("rand_rdy_timeout", oTx_Rdy, 1);
      repeat ($urandom_range(0, 2)) step();
      iTx_Val = 1'b1; iTx_Data = d; iTx_Check_odd = 1'b0; iTx_Check_even = 1'b1;
      sentQ.push_back(d);
      step();
      iTx_Val = 1'b0; iTx_Data = 8'($urandom);
    end
    w = 0;
    while (rxQ.size() < sentQ.size() && w < 1000) begin
      step();
      w++;
    end
    repeat (40) step();
    check("rand_rx_count", rxQ.size(), sentQ.size());
    nRx = (rxQ.size() < sentQ.size()) ? rxQ.size() : sentQ.size();
    errCnt = 0;
    for (int i = 0; i < nRx; i++) begin
      check($sformatf("rand_byte%0d", i), rxQ[i], sentQ[i]);
      errCnt += int'(errQ[i]);
    end
    check("rand_frame_errors", errCnt, 0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
